layer_output_argmax: RTL and testbench

Output stage that drains a finished fully-connected layer through its serial PISO output port. It pulses the layer's `shift` request once per neuron, captures each signed fixed-point result into a local buffer and tracks the running maximum. It then presents the winning class index and its value to the top level and releases the layer with a `restart` pulse. It sits after the last layer, on the receiving end of the `shift` / `SOUT` / `transferred` / `restart` transfer protocol.

---
 rtl/layer_output_argmax.sv | 166 ++++++++++++++++
 tb/tb_layer_output_argmax.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_argmax.sv
// layer_output_argmax
// Drains a finished fully-connected layer through its serial output port.
// Each word is requested with a one-cycle shift pulse, captured into a local
// buffer and compared against the running maximum. The winning class index
// and value are then presented, and the layer is released with a restart pulse.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   neurons_finished   layer holds all NN results
//   transferred        layer has shifted out all NN words
//   layer_sout         current word from the layer (valid one cycle after shift)
//   result_ack         consumer has taken the result
//   shift              one-cycle request for the next word
//   restart            one-cycle pulse returning the layer to idle
//   result_valid       class_idx / max_value / xfer_err are valid
//   class_idx          index of the largest word (0 = first word shifted out)
//   max_value          value of the largest word
//   xfer_err           transferred was low after NN words
//   rd_addr, rd_data   combinational buffer read port (0 beyond NN-1)
module layer_output_argmax #(
    parameter int unsigned DATA_WIDTH = 29,
    parameter int unsigned NN         = 10,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  neurons_finished,
    input  logic                  transferred,
    input  logic [DATA_WIDTH-1:0] layer_sout,
    input  logic                  result_ack,
    output logic                  shift,
    output logic                  restart,
    output logic                  result_valid,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic                  xfer_err,
    input  logic [IDX_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAPT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NN - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  mx_q, mx_d;
    logic [IDX_WIDTH-1:0]   mi_q, mi_d;
    logic [DATA_WIDTH-1:0]  buf_q [NN];
    logic [DATA_WIDTH-1:0]  buf_d [NN];
    logic                   shift_q, shift_d;
    logic                   restart_q, restart_d;
    logic                   result_valid_q, result_valid_d;
    logic [IDX_WIDTH-1:0]   class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0]  max_value_q, max_value_d;
    logic                   xfer_err_q, xfer_err_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mx_d        = mx_q;
        mi_d        = mi_q;
        buf_d       = buf_q;
        class_idx_d = class_idx_q;
        max_value_d = max_value_q;
        xfer_err_d  = xfer_err_q;

        case (state_q)
            S_IDLE: begin
                if (neurons_finished && !transferred) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                buf_d[cnt_q] = layer_sout;
                // Strict greater-than so ties keep the earlier index.
                if (cnt_q == '0 || $signed(layer_sout) > $signed(mx_q)) begin
                    mx_d = layer_sout;
                    mi_d = cnt_q;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d   = cnt_q + IDX_WIDTH'(1);
                    state_d = S_REQ;
                end
            end
            S_CHECK: begin
                xfer_err_d  = ~transferred;
                class_idx_d = mi_q;
                max_value_d = mx_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (result_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the state being entered so they line up
        // exactly with the cycle spent in that state.
        shift_d        = (state_d == S_REQ);
        restart_d      = (state_d == S_CHECK);
        result_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mx_q           <= '0;
            mi_q           <= '0;
            buf_q          <= '{default: '0};
            shift_q        <= 1'b0;
            restart_q      <= 1'b0;
            result_valid_q <= 1'b0;
            class_idx_q    <= '0;
            max_value_q    <= '0;
            xfer_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mx_q           <= mx_d;
            mi_q           <= mi_d;
            buf_q          <= buf_d;
            shift_q        <= shift_d;
            restart_q      <= restart_d;
            result_valid_q <= result_valid_d;
            class_idx_q    <= class_idx_d;
            max_value_q    <= max_value_d;
            xfer_err_q     <= xfer_err_d;
        end
    end

    // Buffer read port; addresses past the last class read as zero.
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < NN) begin
            rd_data = buf_q[rd_addr];
        end
    end

    assign shift        = shift_q;
    assign restart      = restart_q;
    assign result_valid = result_valid_q;
    assign class_idx    = class_idx_q;
    assign max_value    = max_value_q;
    assign xfer_err     = xfer_err_q;

endmodule

// File: tb/tb_layer_output_argmax.sv
// Scoreboard bench for layer_output_argmax: a layer model answers shift
// requests, stimulus pushes hand-computed results, a monitor pops and checks.
module tb_layer_output_argmax;

    localparam int unsigned DW = 29;
    localparam int unsigned NN = 10;
    localparam int unsigned IW = 4;

    logic          clk;
    logic          rstn;
    logic          nf;
    logic          transferred;
    logic [DW-1:0] layer_sout;
    logic          ack;
    logic          shift;
    logic          restart;
    logic          result_valid;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] max_value;
    logic          xfer_err;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    layer_output_argmax #(.DATA_WIDTH(DW), .NN(NN), .IDX_WIDTH(IW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .neurons_finished (nf),
        .transferred      (transferred),
        .layer_sout       (layer_sout),
        .result_ack       (ack),
        .shift            (shift),
        .restart          (restart),
        .result_valid     (result_valid),
        .class_idx        (class_idx),
        .max_value        (max_value),
        .xfer_err         (xfer_err),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data)
    );

    typedef struct {
        int idx;
        int val;
        int err;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    logic [DW-1:0] words [NN];
    int            v [NN];
    int            n_vec = 0;
    int            n_err = 0;
    bit            tx_ok;
    bit            hold_tx;
    int            shift_n;
    int            restart_n;
    int            cyc;
    int            first_shift;
    int            restart_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input int val, input int err);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.err = err;
        sb.push_back(e);
    endtask

    // Layer model: serves words on shift, raises transferred after the last one.
    initial begin
        int wptr;
        wptr        = 0;
        layer_sout  = '0;
        transferred = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                wptr        = 0;
                transferred = 1'b0;
            end else begin
                if (!nf) begin
                    wptr = 0;
                    if (!hold_tx) transferred = 1'b0;
                end
                if (shift) begin
                    layer_sout = words[wptr % NN];
                    wptr++;
                    if (wptr == NN && tx_ok) transferred = 1'b1;
                end
            end
        end
    end

    // Monitor: counts strobes, pops the scoreboard when a result is presented.
    initial begin
        bit prev_v;
        bit prev_s;
        prev_v = 0; prev_s = 0; cyc = 0;
        shift_n = 0; restart_n = 0; first_shift = 0; restart_cyc = 0;
        cur.idx = 0; cur.val = 0; cur.err = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                shift_n = 0; restart_n = 0; prev_v = 0; prev_s = 0;
            end else begin
                if (shift) begin
                    if (shift_n == 0) first_shift = cyc;
                    shift_n++;
                    chk("shift_gap", 64'(prev_s), 0);
                end
                if (restart) begin
                    restart_n++;
                    restart_cyc = cyc;
                end
                if (result_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: got idx %0d with empty scoreboard",
                                 class_idx);
                    end else begin
                        cur = sb.pop_front();
                        chk("class_idx", class_idx, cur.idx);
                        chk("max_value", $signed(max_value), cur.val);
                        chk("xfer_err", xfer_err, cur.err);
                        chk("shift_count", shift_n, NN);
                        chk("restart_count", restart_n, 1);
                        chk("valid_latency", cyc - first_shift, 2 * NN + 1);
                        chk("restart_to_valid", cyc - restart_cyc, 1);
                    end
                    shift_n   = 0;
                    restart_n = 0;
                end else if (result_valid) begin
                    chk("hold_idx", class_idx, cur.idx);
                    chk("hold_val", $signed(max_value), cur.val);
                end
                prev_v = result_valid;
                prev_s = shift;
            end
        end
    end

    task automatic run_xfer(input bit ok, input bit drop);
        bit got;
        for (int i = 0; i < NN; i++) words[i] = DW'(v[i]);
        tx_ok = ok;
        @(negedge clk);
        nf  = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) got = 1;
        end
        chk("result_timeout", 64'(got), 1);
        if (drop) begin
            @(negedge clk);
            nf = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit seen_r;
        rstn = 1'b0; nf = 1'b0; ack = 1'b1; rd_addr = '0;
        tx_ok = 1; hold_tx = 0;
        repeat (3) @(negedge clk);
        chk("rst_shift", shift, 0);
        chk("rst_restart", restart, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_val", $signed(max_value), 0);
        chk("rst_err", xfer_err, 0);
        chk("rst_rd", $signed(rd_data), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Mixed signs, tie between index 2 and 7.
        v = '{5, -3, 12, 7, 0, -20, 11, 12, 1, 2};
        push_exp(2, 12, 0);
        run_xfer(1, 1);

        // All negative.
        v = '{-9, -4, -100, -4, -7, -50, -8, -6, -5, -10};
        push_exp(1, -4, 0);
        run_xfer(1, 1);

        // Most negative word first must lose to everything else.
        v = '{-268435456, -7, -3, -5, -268435456, -8, -9, -3, -2000, -1};
        push_exp(9, -1, 0);
        run_xfer(1, 1);

        // transferred never rises.
        v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        push_exp(5, 9, 1);
        run_xfer(0, 1);

        // Back-to-back with result_ack held high.
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        push_exp(9, 10, 0);
        run_xfer(1, 1);
        v = '{100, -1, 268435455, 3, 268435455, 0, -268435456, 42, 7, 100};
        push_exp(2, 268435455, 0);
        run_xfer(1, 1);
        for (int a = 0; a < 16; a++) begin
            rd_addr = IW'(a);
            #1;
            chk($sformatf("rd_sweep_%0d", a), $signed(rd_data), (a < NN) ? v[a] : 0);
        end
        rd_addr = '0;

        // Reset after the fourth shift aborts without a restart.
        v = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        for (int i = 0; i < NN; i++) words[i] = DW'(v[i]);
        tx_ok = 1;
        @(negedge clk);
        nf = 1'b1;
        got = 0; seen_r = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            if (restart) seen_r = 1;
            if (shift_n >= 4) got = 1;
        end
        chk("abort_timeout", 64'(got), 1);
        chk("abort_buf_before", $signed(rd_data), 7);
        @(negedge clk);
        rstn = 1'b0;
        nf   = 1'b0;
        #1;
        chk("abort_no_restart", 64'(seen_r), 0);
        chk("abort_buf_cleared", $signed(rd_data), 0);
        chk("abort_shift", shift, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
        push_exp(9, 9, 0);
        run_xfer(1, 1);

        // Result held without ack while the layer still reports finished.
        ack     = 1'b0;
        hold_tx = 1;
        v = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        push_exp(0, -1, 0);
        run_xfer(1, 0);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1;
        chk("hold_no_shift", shift_n, 0);
        chk("hold_valid", result_valid, 1);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        chk("no_retrigger", shift_n, 0);
        chk("valid_dropped", result_valid, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
